// File: rtl/btb_predictor_if.sv
// Fetch-lookup / execute-update / invalidate signal bundle for the branch target buffer.
// Protocol: i_upd_vld and i_inv_req are single-cycle strobes sampled on the rising clock; there is no ready, and busy only reports a sweep.
interface btb_predictor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] i_pc_f;
  logic            o_pred_taken;
  logic [XLEN-1:0] o_pred_target;
  logic            i_upd_vld;
  logic [XLEN-1:0] i_upd_pc;
  logic            i_upd_taken;
  logic [XLEN-1:0] i_upd_target;
  logic            i_upd_jump;
  logic            i_upd_mispred;
  logic            i_inv_req;
  logic            o_busy;
  logic [31:0]     o_mispred_cnt;
  logic            o_state;

  modport slave (
    input  i_pc_f, i_upd_vld, i_upd_pc, i_upd_taken, i_upd_target,
           i_upd_jump, i_upd_mispred, i_inv_req,
    output o_pred_taken, o_pred_target, o_busy, o_mispred_cnt, o_state
  );

  modport master (
    output i_pc_f, i_upd_vld, i_upd_pc, i_upd_taken, i_upd_target,
           i_upd_jump, i_upd_mispred, i_inv_req,
    input  o_pred_taken, o_pred_target, o_busy, o_mispred_cnt, o_state
  );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters, a one-entry-per-cycle
// invalidate sweep and a saturating mispredict counter.
module btb_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  btb_predictor_if.slave    bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic             busy_q;
  logic [31:0]      cnt_q;

  logic             valid_q [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-3:0]  tgt_q   [ENTRIES];
  logic             jump_q  [ENTRIES];

  // Fetch lookup reads the registered table, so same-cycle updates are not visible.
  logic [IDX_W-1:0] f_idx;
  logic             f_hit;
  logic             f_taken;

  assign f_idx   = bus.i_pc_f[IDX_W+1:2];
  assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == bus.i_pc_f[XLEN-1:IDX_W+2]);
  assign f_taken = f_hit && (jump_q[f_idx] || ctr_q[f_idx][1]) && !busy_q;

  assign bus.o_pred_taken  = f_taken;
  assign bus.o_pred_target = f_taken ? {tgt_q[f_idx], 2'b00}
                                     : {bus.i_pc_f[XLEN-1:2] + (XLEN-2)'(1), 2'b00};
  assign bus.o_busy        = busy_q;
  assign bus.o_mispred_cnt = cnt_q;
  assign bus.o_state       = state_q;

  logic unused_low_bits;
  assign unused_low_bits = ^{bus.i_pc_f[1:0], bus.i_upd_pc[1:0], bus.i_upd_target[1:0]};

  logic [IDX_W-1:0] u_idx;
  logic             u_hit;
  logic             upd_en;

  assign u_idx  = bus.i_upd_pc[IDX_W+1:2];
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == bus.i_upd_pc[XLEN-1:IDX_W+2]);
  assign upd_en = bus.i_upd_vld && (state_q == IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'd0;
      end
    end else begin
      if (upd_en) begin
        if (u_hit) begin
          if (bus.i_upd_taken) begin
            if (ctr_q[u_idx] != 2'd3) ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
          end else begin
            if (ctr_q[u_idx] != 2'd0) ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
          end
        end else if (bus.i_upd_taken) begin
          valid_q[u_idx] <= 1'b1;
          ctr_q[u_idx]   <= 2'd2;
        end
      end
      // Updates are blocked while sweeping, so the two writes never collide.
      if (state_q == SWEEP) valid_q[ptr_q] <= 1'b0;
    end
  end

  // Payload fields are only meaningful behind valid, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (upd_en && bus.i_upd_taken) begin
      tag_q[u_idx]  <= bus.i_upd_pc[XLEN-1:IDX_W+2];
      tgt_q[u_idx]  <= bus.i_upd_target[XLEN-1:2];
      jump_q[u_idx] <= bus.i_upd_jump;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_inv_req) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          ptr_q <= ptr_q + IDX_W'(1);
          if (ptr_q == IDX_W'(ENTRIES - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (bus.i_upd_vld && bus.i_upd_mispred && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed vector table, hand-written
// sweep/reset sequences and random traffic against a behavioural model.
module tb_btb_predictor;
  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btb_predictor_if #(.XLEN(XLEN)) bif();

  btb_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bif)
  );

  int checks = 0;
  int errors = 0;
  logic [XLEN:0] exp_q[$];

  // Behavioural model: a plain table of entries indexed by (pc/4) mod ENTRIES.
  typedef struct {
    bit          v;
    int unsigned tag;
    int unsigned tgt;
    bit          j;
    int          ctr;
  } ent_t;

  ent_t        m_tab[ENTRIES];
  int          sweep_left;
  int unsigned m_cnt;

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_tab[i].v   = 1'b0;
      m_tab[i].ctr = 0;
    end
    sweep_left = 0;
    m_cnt      = 0;
  endfunction

  function automatic void m_predict(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
    int unsigned idx, tag;
    idx = (pc / 4) % ENTRIES;
    tag = pc / (4 * ENTRIES);
    tk  = (sweep_left == 0) && m_tab[idx].v && (m_tab[idx].tag == tag) &&
          (m_tab[idx].j || m_tab[idx].ctr >= 2);
    tg  = tk ? m_tab[idx].tgt : ((pc / 4) + 1) * 4;
  endfunction

  function automatic void m_clock(input bit vld, input logic [31:0] pc, input bit tk,
                                  input logic [31:0] tgt, input bit j, input bit mp,
                                  input bit inv);
    int unsigned idx, tag;
    if (vld && mp && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    if (sweep_left > 0) begin
      m_tab[ENTRIES - sweep_left].v = 1'b0;
      sweep_left--;
      return;
    end
    if (vld) begin
      idx = (pc / 4) % ENTRIES;
      tag = pc / (4 * ENTRIES);
      if (m_tab[idx].v && m_tab[idx].tag == tag) begin
        m_tab[idx].ctr = tk ? ((m_tab[idx].ctr == 3) ? 3 : m_tab[idx].ctr + 1)
                            : ((m_tab[idx].ctr == 0) ? 0 : m_tab[idx].ctr - 1);
        if (tk) begin
          m_tab[idx].tgt = tgt & 32'hFFFF_FFFC;
          m_tab[idx].j   = j;
        end
      end else if (tk) begin
        m_tab[idx].v   = 1'b1;
        m_tab[idx].tag = tag;
        m_tab[idx].tgt = tgt & 32'hFFFF_FFFC;
        m_tab[idx].j   = j;
        m_tab[idx].ctr = 2;
      end
    end
    if (inv) sweep_left = ENTRIES;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Lookup scoreboard: model expectation queued, compared once outputs settle.
  task automatic check_look(input string name);
    bit            tk;
    logic [31:0]   tg;
    logic [XLEN:0] e;
    m_predict(bif.i_pc_f, tk, tg);
    exp_q.push_back({tk, tg});
    #1;
    e = exp_q.pop_front();
    check($sformatf("%s.taken", name), bif.o_pred_taken, e[XLEN]);
    check($sformatf("%s.target", name), bif.o_pred_target, e[XLEN-1:0]);
    check($sformatf("%s.busy", name), bif.o_busy, sweep_left > 0);
    check($sformatf("%s.cnt", name), bif.o_mispred_cnt, m_cnt);
  endtask

  // Driver tasks
  task automatic drive_upd(input bit vld, input logic [31:0] pc, input bit tk,
                           input logic [31:0] tgt, input bit j, input bit mp);
    bif.i_upd_vld     = vld;
    bif.i_upd_pc      = pc;
    bif.i_upd_taken   = tk;
    bif.i_upd_target  = tgt;
    bif.i_upd_jump    = j;
    bif.i_upd_mispred = mp;
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock(bif.i_upd_vld, bif.i_upd_pc, bif.i_upd_taken, bif.i_upd_target,
            bif.i_upd_jump, bif.i_upd_mispred, bif.i_inv_req);
    #1;
    bif.i_upd_vld = 1'b0;
    bif.i_inv_req = 1'b0;
  endtask

  typedef struct {
    bit          vld;
    logic [31:0] pc;
    bit          tk;
    logic [31:0] tgt;
    bit          j;
    bit          mp;
    logic [31:0] look;
    bit          exp_tk;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[11];

  logic [31:0] pool[8];
  int          busy_cycles;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{0, 32'h00, 0, 32'h000, 0, 0, 32'h40, 0, 32'h44};
    vecs[1]  = '{1, 32'h40, 1, 32'h100, 0, 1, 32'h40, 1, 32'h100};
    vecs[2]  = '{1, 32'h40, 0, 32'h000, 0, 0, 32'h40, 0, 32'h44};
    vecs[3]  = '{1, 32'h40, 0, 32'h000, 0, 1, 32'h40, 0, 32'h44};
    vecs[4]  = '{1, 32'h80, 1, 32'h200, 0, 1, 32'h80, 1, 32'h200};
    vecs[5]  = '{0, 32'h00, 0, 32'h000, 0, 0, 32'h40, 0, 32'h44};
    vecs[6]  = '{1, 32'h84, 1, 32'h300, 1, 1, 32'h84, 1, 32'h300};
    vecs[7]  = '{1, 32'h84, 0, 32'h000, 0, 0, 32'h84, 1, 32'h300};
    vecs[8]  = '{1, 32'h84, 0, 32'h000, 0, 1, 32'h84, 1, 32'h300};
    vecs[9]  = '{1, 32'h84, 0, 32'h000, 0, 0, 32'h84, 1, 32'h300};
    vecs[10] = '{0, 32'h84, 1, 32'h999, 0, 1, 32'h88, 0, 32'h8C};
    pool = '{32'h40, 32'h80, 32'hC0, 32'h44, 32'h84, 32'h1000, 32'h104, 32'h3C};

    drive_upd(0, 0, 0, 0, 0, 0);
    bif.i_inv_req = 1'b0;
    bif.i_pc_f    = 32'h40;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("reset.state", bif.o_state, 0);
    for (int i = 0; i < 11; i++) begin
      drive_upd(vecs[i].vld, vecs[i].pc, vecs[i].tk, vecs[i].tgt, vecs[i].j, vecs[i].mp);
      tick();
      bif.i_pc_f = vecs[i].look;
      check_look($sformatf("vec%0d.model", i));
      check($sformatf("vec%0d.taken", i), bif.o_pred_taken, vecs[i].exp_tk);
      check($sformatf("vec%0d.target", i), bif.o_pred_target, vecs[i].exp_tgt);
    end
    check("mispred_cnt5", bif.o_mispred_cnt, 5);

    // Same-cycle lookup of an index being written sees the old contents.
    drive_upd(1, 32'hC0, 1, 32'h400, 0, 0);
    bif.i_pc_f = 32'hC0;
    check_look("same_pre");
    check("same_pre.taken", bif.o_pred_taken, 0);
    check("same_pre.target", bif.o_pred_target, 32'hC4);
    tick();
    check_look("same_post");
    check("same_post.target", bif.o_pred_target, 32'h400);

    // Update together with invalidate: update lands, then the sweep wipes it.
    drive_upd(1, 32'h10, 1, 32'h500, 0, 0);
    bif.i_inv_req = 1'b1;
    tick();
    busy_cycles = 0;
    for (int c = 0; c < 40 && bif.o_busy === 1'b1; c++) begin
      busy_cycles++;
      if (c == 3) drive_upd(1, 32'h20, 1, 32'h600, 0, 1);
      if (c == 5) bif.i_inv_req = 1'b1;
      bif.i_pc_f = 32'hC0;
      check_look($sformatf("sweep%0d", c));
      check($sformatf("sweep%0d.state", c), bif.o_state, 1);
      tick();
    end
    check("sweep_len", busy_cycles, 16);
    foreach (pool[k]) begin
      bif.i_pc_f = pool[k];
      check_look($sformatf("post_sweep%0d", k));
      check($sformatf("post_sweep%0d.taken", k), bif.o_pred_taken, 0);
    end
    bif.i_pc_f = 32'h10;
    check_look("post_sweep_10");
    bif.i_pc_f = 32'h20;
    check_look("post_sweep_20");
    check("post_sweep.cnt", bif.o_mispred_cnt, 6);

    // Random traffic on an aliasing PC pool.
    for (int n = 0; n < 400; n++) begin
      drive_upd($urandom_range(0, 1), pool[$urandom_range(0, 7)], $urandom_range(0, 1),
                $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 1));
      bif.i_inv_req = ($urandom_range(0, 60) == 0);
      bif.i_pc_f    = pool[$urandom_range(0, 7)];
      check_look($sformatf("rand%0d", n));
      tick();
    end

    // Async reset in the middle of a sweep.
    for (int w = 0; w < 20 && sweep_left > 0; w++) tick();
    drive_upd(1, 32'h84, 1, 32'h700, 1, 1);
    tick();
    bif.i_inv_req = 1'b1;
    tick();
    repeat (4) tick();
    check("midsweep.busy", bif.o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check("rst_async.busy", bif.o_busy, 0);
    check("rst_async.cnt", bif.o_mispred_cnt, 0);
    check("rst_async.state", bif.o_state, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bif.i_pc_f = 32'h84;
    check_look("after_rst_84");
    check("after_rst_84.taken", bif.o_pred_taken, 0);
    tick();
    bif.i_pc_f = 32'h40;
    check_look("after_rst_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
